// File: rtl/debug_input_if.sv
// Board-side signal bundle of the debug input controller: raw switches/buttons in,
// conditioned levels, CPU advance pulse, browse address and cycle count out.
interface debug_input_if #(
   parameter int ADDR_W = 8
);
   logic [15:0]       sw_raw;
   logic              btn_step;
   logic              btn_mode;
   logic              btn_up;
   logic              btn_down;
   logic [15:0]       sw;
   logic              cpu_en;
   logic              run_mode;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       cycle_cnt;

   modport master (
      output sw_raw, btn_step, btn_mode, btn_up, btn_down,
      input  sw, cpu_en, run_mode, sel_addr, cycle_cnt
   );

   modport slave (
      input  sw_raw, btn_step, btn_mode, btn_up, btn_down,
      output sw, cpu_en, run_mode, sel_addr, cycle_cnt
   );
endinterface

// File: rtl/debug_input.sv
// Debug-board front end: sync + debounce of switches/buttons, step/run CPU enable,
// auto-repeating browse address and executed-cycle counter.
//
// state   | meaning
// ST_STEP | cpu_en only on a step press
// ST_RUN  | cpu_en every RUN_DIV clks, step presses ignored
module debug_input #(
   parameter int DEB_CYCLES = 1000000,
   parameter int RUN_DIV    = 50000000,
   parameter int REP_DELAY  = 50000000,
   parameter int REP_RATE   = 10000000,
   parameter int ADDR_W     = 8
) (
   input logic         clk,
   input logic         rst_n,
   debug_input_if.slave io
);

   localparam int NIN = 20;
   localparam int DW  = $clog2(DEB_CYCLES + 1);
   localparam int RW  = $clog2(RUN_DIV);
   localparam int PW  = $clog2(REP_DELAY + 1);

   localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
   localparam logic [RW-1:0] DIV_LAST   = RW'(RUN_DIV - 1);
   localparam logic [PW-1:0] REP_FIRE   = PW'(REP_DELAY);
   localparam logic [PW-1:0] REP_RELOAD = PW'(REP_DELAY - REP_RATE + 1);

   typedef enum logic {ST_STEP, ST_RUN} mode_e;

   // bit map: [15:0] switches, 16 step, 17 mode, 18 up, 19 down
   logic [NIN-1:0] raw;
   logic [NIN-1:0] sync1_q, sync2_q;
   logic [NIN-1:0] lvl_q, lvl_d;
   logic [DW-1:0]  deb_cnt_q [NIN];
   logic [DW-1:0]  deb_cnt_d [NIN];
   logic [3:0]     btn_prev_q;
   logic [3:0]     btn_press;

   mode_e          state_q, state_d;
   logic [RW-1:0]  div_q, div_d;
   logic           cpu_en_q, cpu_en_d;
   logic [31:0]    cycle_cnt_q;

   logic [PW-1:0]     rep_q, rep_d;
   logic              rep_fire;
   logic              one_held;
   logic              addr_inc, addr_dec;
   logic [ADDR_W-1:0] sel_q, sel_d;

   assign raw = {io.btn_down, io.btn_up, io.btn_mode, io.btn_step, io.sw_raw};

   always_comb begin
      lvl_d = lvl_q;
      for (int i = 0; i < NIN; i++) begin
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != lvl_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) lvl_d[i] = ~lvl_q[i];
            else                          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
         end
      end
   end

   assign btn_press = lvl_q[19:16] & ~btn_prev_q;

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      cpu_en_d = 1'b0;
      case (state_q)
         ST_STEP: begin
            if (btn_press[1]) begin
               state_d = ST_RUN;
               div_d   = '0;
            end else begin
               cpu_en_d = btn_press[0];
            end
         end
         ST_RUN: begin
            // a mode press beats a pulse that would land on the same edge
            if (btn_press[1]) begin
               state_d = ST_STEP;
               div_d   = '0;
            end else if (div_q == DIV_LAST) begin
               cpu_en_d = 1'b1;
               div_d    = '0;
            end else begin
               div_d = div_q + RW'(1);
            end
         end
         default: state_d = ST_STEP;
      endcase
   end

   assign one_held = lvl_q[18] ^ lvl_q[19];

   always_comb begin
      rep_d    = '0;
      rep_fire = 1'b0;
      if (one_held) begin
         if (rep_q == REP_FIRE) begin
            rep_fire = 1'b1;
            rep_d    = REP_RELOAD;
         end else begin
            rep_d = rep_q + PW'(1);
         end
      end
   end

   assign addr_inc = btn_press[2] | (rep_fire & lvl_q[18]);
   assign addr_dec = btn_press[3] | (rep_fire & lvl_q[19]);

   always_comb begin
      sel_d = sel_q;
      if (addr_inc && !addr_dec)      sel_d = sel_q + ADDR_W'(1);
      else if (addr_dec && !addr_inc) sel_d = sel_q - ADDR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         lvl_q      <= '0;
         btn_prev_q <= '0;
         for (int i = 0; i < NIN; i++) deb_cnt_q[i] <= '0;
      end else begin
         sync1_q    <= raw;
         sync2_q    <= sync1_q;
         lvl_q      <= lvl_d;
         btn_prev_q <= lvl_q[19:16];
         for (int i = 0; i < NIN; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_STEP;
         div_q       <= '0;
         cpu_en_q    <= 1'b0;
         cycle_cnt_q <= '0;
         rep_q       <= '0;
         sel_q       <= '0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         cpu_en_q    <= cpu_en_d;
         cycle_cnt_q <= cycle_cnt_q + {31'd0, cpu_en_d};
         rep_q       <= rep_d;
         sel_q       <= sel_d;
      end
   end

   assign io.sw        = lvl_q[15:0];
   assign io.cpu_en    = cpu_en_q;
   assign io.run_mode  = (state_q == ST_RUN);
   assign io.sel_addr  = sel_q;
   assign io.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_debug_input.sv
// Bench for debug_input: directed scenarios with literal expectations, then random
// button/switch activity compared every cycle against a window-based behavioural model.
module tb_debug_input;
   localparam int DEB   = 4;
   localparam int RDIV  = 8;
   localparam int RDLY  = 16;
   localparam int RRATE = 4;
   localparam int AW    = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   debug_input_if #(.ADDR_W(AW)) bus ();

   debug_input #(
      .DEB_CYCLES(DEB), .RUN_DIV(RDIV), .REP_DELAY(RDLY), .REP_RATE(RRATE), .ADDR_W(AW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .io   (bus)
   );

   int errors = 0;
   int checks = 0;

   // model state
   logic [19:0]   rawq[$];
   logic [19:0]   m_lvl;
   logic [19:0]   m_prev;
   bit            m_run;
   bit            m_en;
   int            m_entry;
   int            m_n;
   int            m_h;
   logic [AW-1:0] m_sel;
   logic [31:0]   m_cnt;
   bit            chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      rawq.delete();
      for (int i = 0; i < DEB + 2; i++) rawq.push_back(20'd0);
      m_lvl = '0; m_prev = '0; m_run = 0; m_en = 0;
      m_entry = 0; m_n = 0; m_h = 0; m_sel = '0; m_cnt = '0;
   endtask

   // One clock edge of the reference: synced input = raw from two edges ago;
   // a debounced bit flips once its last DEB synced samples all disagree with it.
   task automatic model_step();
      logic [19:0] raw, old_lvl;
      logic [3:0]  press;
      bit          one, fire, inc, dec, all_diff;
      int          n;
      raw     = {bus.btn_down, bus.btn_up, bus.btn_mode, bus.btn_step, bus.sw_raw};
      old_lvl = m_lvl;
      press   = old_lvl[19:16] & ~m_prev[19:16];
      n       = m_n;
      m_n++;
      if (press[1]) begin
         m_run   = !m_run;
         m_entry = n;
         m_en    = 0;
      end else if (m_run) begin
         m_en = ((n - m_entry) % RDIV) == 0;
      end else begin
         m_en = press[0];
      end
      m_cnt = m_cnt + (m_en ? 32'd1 : 32'd0);
      one = old_lvl[18] ^ old_lvl[19];
      if (one) m_h++;
      else     m_h = 0;
      fire = one && (m_h > RDLY) && (((m_h - RDLY - 1) % RRATE) == 0);
      inc  = press[2] || (fire && old_lvl[18]);
      dec  = press[3] || (fire && old_lvl[19]);
      if (inc && !dec) m_sel = m_sel + 1'b1;
      if (dec && !inc) m_sel = m_sel - 1'b1;
      rawq.push_front(raw);
      void'(rawq.pop_back());
      for (int b = 0; b < 20; b++) begin
         all_diff = 1;
         for (int j = 2; j < DEB + 2; j++)
            if (rawq[j][b] == old_lvl[b]) all_diff = 0;
         if (all_diff) m_lvl[b] = ~old_lvl[b];
      end
      m_prev = old_lvl;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("sw",        64'(bus.sw),        64'(m_lvl[15:0]));
         chk("cpu_en",    64'(bus.cpu_en),    64'(m_en));
         chk("run_mode",  64'(bus.run_mode),  64'(m_run));
         chk("sel_addr",  64'(bus.sel_addr),  64'(m_sel));
         chk("cycle_cnt", 64'(bus.cycle_cnt), 64'(m_cnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rst_n) model_step();
   endtask

   task automatic do_reset();
      chk_en = 0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_sw",        64'(bus.sw),        64'd0);
      chk("rst_cpu_en",    64'(bus.cpu_en),    64'd0);
      chk("rst_run_mode",  64'(bus.run_mode),  64'd0);
      chk("rst_sel_addr",  64'(bus.sel_addr),  64'd0);
      chk("rst_cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      chk_en = 1;
   endtask

   task automatic press_btn(input int which, input int hold);
      case (which)
         0: bus.btn_step = 1'b1;
         1: bus.btn_mode = 1'b1;
         2: bus.btn_up   = 1'b1;
         default: bus.btn_down = 1'b1;
      endcase
      repeat (hold) tick();
      bus.btn_step = 1'b0; bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
      repeat (hold) tick();
   endtask

   initial begin
      int pulses, t, d;
      logic [AW-1:0] prev;
      int chg[$];

      bus.sw_raw = '0; bus.btn_step = 0; bus.btn_mode = 0; bus.btn_up = 0; bus.btn_down = 0;
      do_reset();

      // 1: 3-clk glitch ignored, stable level appears 6 clks after its edge
      bus.sw_raw[3] = 1'b1;
      repeat (3) tick();
      bus.sw_raw[3] = 1'b0;
      repeat (3) tick();
      bus.sw_raw[3] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("t1_sw3", 64'(bus.sw[3]), (k >= 6) ? 64'd1 : 64'd0);
      end

      // 2: three single-step presses
      pulses = 0;
      for (int r = 0; r < 3; r++) begin
         bus.btn_step = 1'b1;
         repeat (20) begin tick(); pulses += int'(bus.cpu_en); end
         bus.btn_step = 1'b0;
         repeat (20) begin tick(); pulses += int'(bus.cpu_en); end
      end
      chk("t2_pulses", 64'(pulses), 64'd3);
      chk("t2_cnt", 64'(bus.cycle_cnt), 64'd3);
      chk("t2_run", 64'(bus.run_mode), 64'd0);

      // 3: enter run mode, first pulse 8 clks after entry, then every 8
      bus.btn_mode = 1'b1;
      t = 0;
      while (!bus.run_mode && t < 50) begin tick(); t++; end
      chk("t3_run", 64'(bus.run_mode), 64'd1);
      d = 0;
      while (!bus.cpu_en && d < 20) begin tick(); d++; end
      chk("t3_first", 64'(d), 64'd8);
      bus.btn_mode = 1'b0;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         bus.btn_step = ((k / 10) % 2) == 0;
         tick();
         pulses += int'(bus.cpu_en);
      end
      bus.btn_step = 1'b0;
      chk("t3_pulses", 64'(pulses), 64'd5);

      // 4: address wrap both ways, simultaneous press is a no-op
      press_btn(3, 10);
      chk("t4_down_wrap", 64'(bus.sel_addr), 64'hFF);
      press_btn(2, 10);
      chk("t4_up_wrap", 64'(bus.sel_addr), 64'h00);
      press_btn(3, 10);
      chk("t4_down", 64'(bus.sel_addr), 64'hFF);
      bus.btn_up = 1'b1; bus.btn_down = 1'b1;
      repeat (10) tick();
      bus.btn_up = 1'b0; bus.btn_down = 1'b0;
      repeat (10) tick();
      chk("t4_both", 64'(bus.sel_addr), 64'hFF);

      // 5: held up button: press step, repeat at +16, then every 4
      prev = bus.sel_addr;
      bus.btn_up = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         if (k == 41) bus.btn_up = 1'b0;
         tick();
         if (bus.sel_addr != prev) begin chg.push_back(k); prev = bus.sel_addr; end
      end
      chk("t5_final", 64'(bus.sel_addr), 64'h06);
      chk("t5_steps", 64'(chg.size()), 64'd7);
      if (chg.size() >= 3) begin
         chk("t5_delay", 64'(chg[1] - chg[0]), 64'd16);
         chk("t5_rate",  64'(chg[2] - chg[1]), 64'd4);
      end

      // 6: reset while running with cycle_cnt = 5
      do_reset();
      press_btn(1, 10);
      t = 0;
      while (bus.cycle_cnt != 32'd5 && t < 200) begin tick(); t++; end
      chk("t6_cnt5", 64'(bus.cycle_cnt), 64'd5);
      chk("t6_run", 64'(bus.run_mode), 64'd1);
      do_reset();
      pulses = 0;
      repeat (30) begin tick(); pulses += int'(bus.cpu_en); end
      chk("t6_idle_pulses", 64'(pulses), 64'd0);
      chk("t6_idle_run", 64'(bus.run_mode), 64'd0);
      press_btn(0, 10);
      chk("t6_step_cnt", 64'(bus.cycle_cnt), 64'd1);

      // random activity
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 15) == 0) bus.btn_step = ~bus.btn_step;
         if ($urandom_range(0, 19) == 0) bus.btn_mode = ~bus.btn_mode;
         if ($urandom_range(0, 27) == 0) bus.btn_up   = ~bus.btn_up;
         if ($urandom_range(0, 27) == 0) bus.btn_down = ~bus.btn_down;
         if ($urandom_range(0, 3) == 0)  bus.sw_raw[$urandom_range(0, 15)] ^= 1'b1;
         if ($urandom_range(0, 799) == 0) do_reset();
         tick();
      end

      repeat (2) @(negedge clk);
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
